// File: rtl/game_render_sequencer.sv
// rtl/game_render_sequencer.sv - frame render sequencer: background, objects per class, hook, frame wait
module game_render_sequencer #(
    parameter int NUM_CLASSES = 3,
    parameter int CW          = 3,
    parameter int MAX_OBJ     = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      go,
    input  logic [NUM_CLASSES*CW-1:0] class_target,
    input  logic                      bg_done,
    input  logic                      obj_done,
    input  logic                      hook_done,
    input  logic                      frame_tick,
    input  logic                      game_end,
    output logic                      enable_draw_background,
    output logic                      enable_random,
    output logic [NUM_CLASSES-1:0]    enable_draw_obj,
    output logic [CW-1:0]             obj_class,
    output logic [CW-1:0]             obj_index,
    output logic                      enable_draw_hook,
    output logic                      clear_objects,
    output logic                      placing,
    output logic                      frame_done
);

    // class counter must be able to hold NUM_CLASSES itself (the "all classes done" value)
    localparam int CLW = $clog2(NUM_CLASSES + 1);

    typedef enum logic [3:0] {
        IDLE, BG, SEL, RAND_X, RAND_Y, DRAW_OBJ, HOOK, HOOK_WAIT, FRAME_WAIT, DONE
    } state_t;

    state_t           state;
    logic [CLW-1:0]   class_cnt;
    logic [CW-1:0]    idx;
    logic [CW-1:0]    tgt [NUM_CLASSES];
    logic [CW-1:0]    cur_tgt;
    logic             placing_r;
    logic             frame_done_r;

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v);
        return (v > CW'(MAX_OBJ)) ? CW'(MAX_OBJ) : v;
    endfunction

    always_comb begin
        cur_tgt = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (class_cnt == CLW'(c)) cur_tgt = tgt[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            class_cnt    <= '0;
            idx          <= '0;
            placing_r    <= 1'b1;
            frame_done_r <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) tgt[c] <= '0;
        end else begin
            frame_done_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        for (int c = 0; c < NUM_CLASSES; c++)
                            tgt[c] <= clamp(class_target[c*CW +: CW]);
                        placing_r <= 1'b1;
                        state     <= BG;
                    end
                end
                BG: begin
                    if (bg_done) begin
                        class_cnt <= '0;
                        idx       <= '0;
                        state     <= SEL;
                    end
                end
                SEL: begin
                    if (class_cnt == CLW'(NUM_CLASSES)) begin
                        state <= HOOK;
                    end else if (idx == cur_tgt) begin
                        class_cnt <= class_cnt + 1'b1;
                        idx       <= '0;
                    end else begin
                        state <= placing_r ? RAND_X : DRAW_OBJ;
                    end
                end
                RAND_X: state <= RAND_Y;
                RAND_Y: state <= DRAW_OBJ;
                DRAW_OBJ: begin
                    if (obj_done) begin
                        idx   <= idx + 1'b1;
                        state <= SEL;
                    end
                end
                HOOK: state <= HOOK_WAIT;
                HOOK_WAIT: begin
                    if (hook_done) begin
                        frame_done_r <= 1'b1;
                        state        <= FRAME_WAIT;
                    end
                end
                FRAME_WAIT: begin
                    // game_end wins over a coincident frame_tick
                    if (game_end) begin
                        state <= DONE;
                    end else if (frame_tick) begin
                        placing_r <= 1'b0;
                        state     <= BG;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic addr_valid;
    assign addr_valid = (state == RAND_X) || (state == RAND_Y) || (state == DRAW_OBJ);

    assign enable_draw_background = (state == BG);
    assign enable_random          = (state == RAND_X) || (state == RAND_Y);
    assign enable_draw_hook       = (state == HOOK);
    assign clear_objects          = (state == DONE);
    assign placing                = placing_r && (state != IDLE) && (state != DONE);
    assign frame_done             = frame_done_r;
    assign obj_class              = addr_valid ? CW'(class_cnt) : '0;
    assign obj_index              = addr_valid ? idx : '0;

    always_comb begin
        enable_draw_obj = '0;
        if (state == DRAW_OBJ) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (class_cnt == CLW'(c)) enable_draw_obj[c] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_render_sequencer.sv
// tb/tb_game_render_sequencer.sv - scoreboard bench for game_render_sequencer
module tb_game_render_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [5:0] class_target;
    logic       bg_done, obj_done, hook_done;
    logic       frame_tick, game_end;
    logic       enable_draw_background, enable_random, enable_draw_hook;
    logic       clear_objects, placing, frame_done;
    logic [1:0] enable_draw_obj;
    logic [2:0] obj_class, obj_index;

    logic auto;
    logic r_bg, r_obj, r_hook, hook_prev;
    logic m_obj, m_hook;

    int checks, failures;
    int rand_cnt, fd_cnt;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    game_render_sequencer #(.NUM_CLASSES(2), .CW(3), .MAX_OBJ(5)) dut (
        .clk(clk), .reset(rst), .go(go), .class_target(class_target),
        .bg_done(bg_done), .obj_done(obj_done), .hook_done(hook_done),
        .frame_tick(frame_tick), .game_end(game_end),
        .enable_draw_background(enable_draw_background), .enable_random(enable_random),
        .enable_draw_obj(enable_draw_obj), .obj_class(obj_class), .obj_index(obj_index),
        .enable_draw_hook(enable_draw_hook), .clear_objects(clear_objects),
        .placing(placing), .frame_done(frame_done)
    );

    // engines answer one cycle after each request
    always @(negedge clk) begin
        r_bg      = enable_draw_background;
        r_obj     = (enable_draw_obj != 2'b00);
        r_hook    = hook_prev;
        hook_prev = enable_draw_hook;
    end
    assign bg_done   = auto ? r_bg   : 1'b0;
    assign obj_done  = auto ? r_obj  : m_obj;
    assign hook_done = auto ? r_hook : m_hook;

    logic [13:0] all_outs;
    assign all_outs = {enable_draw_background, enable_random, enable_draw_obj, obj_class,
                       obj_index, enable_draw_hook, clear_objects, placing, frame_done};

    function automatic logic [15:0] ev(input logic [1:0] k, input logic [1:0] vec,
                                       input logic [2:0] c, input logic [2:0] i, input logic p);
        return {k, vec, c, i, p, 5'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb(input string name, input logic [15:0] act);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: unexpected event %0h, expected none", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, {16'd0, act}, {16'd0, e});
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (enable_random) rand_cnt++;
                if (enable_draw_obj != 2'b00)
                    sb("draw", ev(2'd1, enable_draw_obj, obj_class, obj_index, placing));
                if (enable_draw_hook)
                    sb("hook", ev(2'd2, enable_draw_obj, obj_class, obj_index, placing));
                if (frame_done) begin
                    sb("frame_done", ev(2'd3, enable_draw_obj, obj_class, obj_index, placing));
                    fd_cnt++;
                end
            end
        end
    endtask

    task automatic push_frame(input int t0, input int t1, input logic p);
        for (int i = 0; i < t0; i++) exp_q.push_back(ev(2'd1, 2'b01, 3'd0, 3'(i), p));
        for (int i = 0; i < t1; i++) exp_q.push_back(ev(2'd1, 2'b10, 3'd1, 3'(i), p));
        exp_q.push_back(ev(2'd2, 2'b00, 3'd0, 3'd0, p));
        exp_q.push_back(ev(2'd3, 2'b00, 3'd0, 3'd0, p));
    endtask

    task automatic wait_fd(input int n0, input int budget);
        bit got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (fd_cnt != n0) begin
                got = 1'b1;
                break;
            end
        end
        check("frame_done_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        #1;
        go = 1'b0;
    endtask

    int  r0, n0;
    bit  seen;

    initial begin
        rst = 1'b1; go = 1'b0; class_target = '0; frame_tick = 1'b0; game_end = 1'b0;
        auto = 1'b1; m_obj = 1'b0; m_hook = 1'b0; hook_prev = 1'b0;
        checks = 0; failures = 0; rand_cnt = 0; fd_cnt = 0;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        #1;
        check("reset_outs", {18'd0, all_outs}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle_outs", {18'd0, all_outs}, 32'd0);

        // placement frame: c0=2, c1=1
        class_target = {3'd1, 3'd2};
        push_frame(2, 1, 1'b1);
        r0 = rand_cnt; n0 = fd_cnt;
        pulse_go();
        check("go_to_bg", {30'd0, enable_draw_background, placing}, 32'd3);
        wait_fd(n0, 200);
        check("rand_placement", rand_cnt - r0, 32'd6);

        // redraw frame
        push_frame(2, 1, 1'b0);
        r0 = rand_cnt; n0 = fd_cnt;
        frame_tick = 1'b1;
        @(negedge clk);
        #1;
        frame_tick = 1'b0;
        check("redraw_bg", {30'd0, enable_draw_background, placing}, 32'd2);
        wait_fd(n0, 200);
        check("rand_redraw", rand_cnt - r0, 32'd0);

        // game_end and frame_tick together
        game_end = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        #1;
        game_end = 1'b0; frame_tick = 1'b0;
        check("done_clear", {29'd0, clear_objects, enable_draw_background, placing}, 32'd4);
        @(negedge clk);
        #1;
        check("done_hold", {31'd0, clear_objects}, 32'd1);

        // zero and clamped targets: c0=0, c1=7 -> 5
        class_target = {3'd7, 3'd0};
        push_frame(0, 5, 1'b1);
        r0 = rand_cnt; n0 = fd_cnt;
        pulse_go();
        check("rego_bg", {29'd0, enable_draw_background, placing, clear_objects}, 32'd6);
        wait_fd(n0, 300);
        check("rand_clamped", rand_cnt - r0, 32'd10);

        // stray handshakes in BG are ignored
        auto = 1'b0;
        frame_tick = 1'b1;
        @(negedge clk);
        #1;
        frame_tick = 1'b0;
        check("stray_entry", {31'd0, enable_draw_background}, 32'd1);
        m_obj = 1'b1; m_hook = 1'b1; go = 1'b1;
        @(negedge clk);
        #1;
        m_obj = 1'b0; m_hook = 1'b0; go = 1'b0;
        check("stray_hold", {27'd0, enable_draw_background, enable_draw_hook, enable_draw_obj, placing},
              32'h10);

        // async reset while in DRAW_OBJ; counters must still start at (1,0)
        exp_q.push_back(ev(2'd1, 2'b10, 3'd1, 3'd0, 1'b0));
        auto = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #2;
            if (enable_draw_obj != 2'b00) begin
                seen = 1'b1;
                break;
            end
        end
        check("reach_draw", {31'd0, seen}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset_outs", {18'd0, all_outs}, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("idle_after_reset", {18'd0, all_outs}, 32'd0);

        // recovery: c0=1, c1=0
        class_target = {3'd0, 3'd1};
        push_frame(1, 0, 1'b1);
        r0 = rand_cnt; n0 = fd_cnt;
        pulse_go();
        wait_fd(n0, 200);
        check("rand_recovery", rand_cnt - r0, 32'd2);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_render_sequencer.md
# game_render_sequencer

Parametrised frame-render sequencer for the Gold Miner VGA view. It steps the draw engines through one frame: background, then every object of every object class, then the hook, and then waits for the next frame tick. Object classes (gold, stone, diamond, ...) and per-class counts are parameters and run-time targets rather than fixed. Random placement runs only on the first frame of a level; later frames redraw the stored objects without calling the random generator.

## Interface
Parameters:
- NUM_CLASSES, default 3: number of object classes; class 0 is drawn first.
- CW, default 3: width of the per-class count and index fields.
- MAX_OBJ, default 5: hard cap on objects per class; must satisfy MAX_OBJ < 2^CW.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- go  in  1  starts a level; sampled in IDLE and DONE only.
- class_target  in  NUM_CLASSES*CW  objects per class; class c occupies bits [c*CW +: CW]; latched on go.
- bg_done  in  1  background engine finished.
- obj_done  in  1  object engine finished the current object.
- hook_done  in  1  hook engine finished.
- frame_tick  in  1  one-cycle frame strobe.
- game_end  in  1  level is over.
- enable_draw_background  out  1  background draw request.
- enable_random  out  1  advance the random generator.
- enable_draw_obj  out  NUM_CLASSES  one-hot draw request for the current class.
- obj_class  out  CW  index of the current class.
- obj_index  out  CW  index of the current object within its class.
- enable_draw_hook  out  1  one-cycle hook draw start.
- clear_objects  out  1  clears the object store in the datapath.
- placing  out  1  high while the placement (first) frame is in progress.
- frame_done  out  1  one-cycle pulse when a frame's drawing completes.

## Operation
- States: IDLE, BG, SEL, RAND_X, RAND_Y, DRAW_OBJ, HOOK, HOOK_WAIT, FRAME_WAIT, DONE.
- Outputs are Moore, decoded from the registered state. All outputs are 0 in IDLE and immediately after reset.
- Reset values: state=IDLE, class counter=0, index counter=0, placing=1, latched targets=0.
- IDLE: on go, latch the targets, clamping each field to MAX_OBJ; set placing=1; go to BG.
- BG: enable_draw_background=1. On bg_done, clear the class and index counters and go to SEL.
- SEL: takes 1 cycle and asserts no outputs.
  - If the class counter equals NUM_CLASSES, go to HOOK.
  - Else if the index equals the class target (this includes a target of 0), increment the class, clear the index, and stay in SEL.
  - Else go to RAND_X if placing=1, otherwise go to DRAW_OBJ.
- RAND_X and RAND_Y: enable_random=1 for exactly one cycle each, then go to DRAW_OBJ.
- DRAW_OBJ: enable_draw_obj[class]=1, with obj_class and obj_index valid and stable. On obj_done, increment the index and go to SEL.
- HOOK: enable_draw_hook=1 for one cycle, then go to HOOK_WAIT.
- HOOK_WAIT: wait for hook_done, then go to FRAME_WAIT. frame_done pulses on that transition (registered: high during the first FRAME_WAIT cycle).
- FRAME_WAIT: sampling order each cycle:
  - game_end has priority: go to DONE.
  - Else on frame_tick, set placing=0 and go to BG.
  - If both are high in the same cycle, go to DONE.
- DONE: clear_objects=1 on every cycle in DONE. On go, re-latch the targets, set placing=1, and go to BG.
- Done inputs are sampled only in their own wait states; any done that arrives elsewhere is ignored.
- frame_tick arriving outside FRAME_WAIT is not remembered.
- go outside IDLE and DONE is ignored.
- reset asserted mid-frame, from any state, returns the block to IDLE asynchronously. No partial enable survives the next edge.

## Timing
- go sampled at edge N gives BG at N+1.
- bg_done at edge M gives SEL at M+1.
- Per object on a placement frame: SEL, RAND_X, RAND_Y, then DRAW_OBJ, i.e. 3 cycles plus the engine latency.
- Per object on a redraw frame: SEL, then DRAW_OBJ.
- Each class with a target of 0 costs one SEL cycle.
- obj_done sampled while in DRAW_OBJ at edge K gives SEL at K+1 with the index already incremented.
- enable_draw_obj must be one-hot or zero in every cycle.

## Test plan
- Placement frame: NUM_CLASSES=2, targets {c0=2, c1=1}, each done asserted 1 cycle after its request.
  - Required: enable_random pulses exactly 6 times.
  - Required: draw sequence (class,index) = (0,0), (0,1), (1,0); then one hook pulse; then frame_done; placing=1 throughout.
- Redraw frame: continue with frame_tick in FRAME_WAIT.
  - Required: placing=0; same draw sequence; enable_random never asserts.
- Zero and clamped targets: targets {c0=0, c1=7}, MAX_OBJ=5.
  - Required: no class-0 requests; class 1 drawn at indices 0-4 only.
- Simultaneous events: game_end and frame_tick both high in FRAME_WAIT.
  - Required: DONE next cycle with clear_objects=1; later go re-enters BG with placing=1.
- Async reset: assert reset in DRAW_OBJ between clock edges.
  - Required: all outputs 0 before the next edge; block stays in IDLE until go.
- Stray handshakes: pulse obj_done and hook_done while in BG, and assert go mid-frame.
  - Required: no state advance; counters unchanged.
